// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    MEM_WAIT   = 2'b10,
    FLUSH      = 2'b11
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; master is the datapath, slave the controller.
interface pipeline_hazard_ctrl_if;

  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       ex_mem_read;
  logic [4:0] ex_write_register;
  logic       ex_branch_taken;
  logic       ex_jump;
  logic       mem_busy;
  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic       pipe_freeze;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_write_register,
           ex_branch_taken, ex_jump, mem_busy,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_write_register,
           ex_branch_taken, ex_jump, mem_busy,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter clocked with the pipeline (falling edge), async active-low reset.
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up on inc, holding at all-ones.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      count <= {CNT_W{1'b0}};
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / redirect / memory-freeze controller for the 5-stage pipeline.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_hazard_ctrl_if.slave hif,
  output logic [1:0]           ctrl_state,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_events
);

  ctrl_state_t state_r, state_nxt_s;
  logic        pending_flush_r, pending_flush_nxt_s;
  logic        load_use_s, redirect_s;
  logic        pc_write_s, if_id_write_s, if_id_flush_s, id_ex_bubble_s, pipe_freeze_s;

  assign load_use_s = hif.ex_mem_read && (hif.ex_write_register != REG_ZERO) &&
                      ((hif.ex_write_register == hif.id_rs) ||
                       (hif.id_uses_rt && (hif.ex_write_register == hif.id_rt)));
  assign redirect_s = hif.ex_branch_taken || hif.ex_jump;

  // State and pending-flush registers, updated with the pipeline registers.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= RUN;
      pending_flush_r <= 1'b0;
    end else begin
      state_r         <= state_nxt_s;
      pending_flush_r <= pending_flush_nxt_s;
    end
  end

  // Next-state and Mealy control outputs; priority mem_busy > redirect > load_use.
  always_comb begin
    state_nxt_s         = state_r;
    pending_flush_nxt_s = pending_flush_r;
    pc_write_s          = 1'b1;
    if_id_write_s       = 1'b1;
    if_id_flush_s       = 1'b0;
    id_ex_bubble_s      = 1'b0;
    pipe_freeze_s       = 1'b0;
    case (state_r)
      RUN, LOAD_STALL: begin
        if (hif.mem_busy) begin
          pipe_freeze_s       = 1'b1;
          pc_write_s          = 1'b0;
          if_id_write_s       = 1'b0;
          pending_flush_nxt_s = redirect_s;
          state_nxt_s         = MEM_WAIT;
        end else if (redirect_s) begin
          if_id_flush_s  = 1'b1;
          id_ex_bubble_s = 1'b1;
          state_nxt_s    = RUN;
        end else if (load_use_s && (state_r == RUN)) begin
          // The bubble inserted here already resolves the hazard seen in LOAD_STALL.
          pc_write_s     = 1'b0;
          if_id_write_s  = 1'b0;
          id_ex_bubble_s = 1'b1;
          state_nxt_s    = LOAD_STALL;
        end else begin
          state_nxt_s = RUN;
        end
      end
      MEM_WAIT: begin
        pipe_freeze_s       = 1'b1;
        pc_write_s          = 1'b0;
        if_id_write_s       = 1'b0;
        pending_flush_nxt_s = pending_flush_r || redirect_s;
        if (!hif.mem_busy) begin
          state_nxt_s = (pending_flush_r || redirect_s) ? FLUSH : RUN;
        end else begin
          state_nxt_s = MEM_WAIT;
        end
      end
      FLUSH: begin
        // A mem_busy seen here is picked up by RUN on the next cycle.
        if_id_flush_s       = 1'b1;
        id_ex_bubble_s      = 1'b1;
        pending_flush_nxt_s = 1'b0;
        state_nxt_s         = RUN;
      end
      default: begin
        state_nxt_s         = RUN;
        pending_flush_nxt_s = 1'b0;
      end
    endcase
    if (!reset) begin
      pc_write_s      = 1'b0;
      if_id_write_s   = 1'b0;
      if_id_flush_s   = 1'b0;
      id_ex_bubble_s  = 1'b0;
      pipe_freeze_s   = 1'b0;
    end else begin
      pipe_freeze_s   = pipe_freeze_s;
    end
  end

  assign hif.pc_write     = pc_write_s;
  assign hif.if_id_write  = if_id_write_s;
  assign hif.if_id_flush  = if_id_flush_s;
  assign hif.id_ex_bubble = id_ex_bubble_s;
  assign hif.pipe_freeze  = pipe_freeze_s;
  assign ctrl_state       = state_r;

`ifdef HAZARD_PERF_CNT_EN
  logic stall_inc_s, flush_inc_s;

  assign stall_inc_s = (state_r == LOAD_STALL) || (state_r == MEM_WAIT);
  assign flush_inc_s = (state_r == FLUSH) ||
                       (((state_r == RUN) || (state_r == LOAD_STALL)) &&
                        !hif.mem_busy && redirect_s);

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc_s),
    .count (stall_cycles)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc_s),
    .count (flush_events)
  );
`else
  assign stall_cycles = {CNT_W{1'b0}};
  assign flush_events = {CNT_W{1'b0}};
`endif

endmodule
